// File: rtl/booth_pp_pipe.sv
// Two-stage elastic radix-8 Booth partial-product generator (X multiples + digit codes, then select/negate).
// Optional feature macro: BOOTH_PP_ONECOMP_EN (one's-complement negatives with pp_neg correction bits).
module booth_pp_pipe #(
    parameter  int NBIT    = 24,
    parameter  int TAG_W   = 4,
    localparam int NUM_PP  = NBIT / 3 + 1,
    localparam int PP_NBIT = NBIT + 3
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic                            tc,
    input  logic [NBIT-1:0]                 x,
    input  logic [NBIT-1:0]                 y,
    input  logic [TAG_W-1:0]                in_tag,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [NUM_PP-1:0][PP_NBIT-1:0]  pp,
    output logic [NUM_PP-1:0]               pp_neg,
    output logic [TAG_W-1:0]                out_tag
);

    localparam int YW = 3 * NUM_PP;

    // sel is one-hot over {4X, 3X, 2X, X}; all-zero means digit 0 and never carries neg
    typedef struct packed {
        logic       neg;
        logic [3:0] sel;
    } code_t;

    function automatic code_t booth_encode(input logic [3:0] t);
        code_t c;
        c = '0;
        case (t)
            4'b0001, 4'b0010: c.sel = 4'b0001;
            4'b0011, 4'b0100: c.sel = 4'b0010;
            4'b0101, 4'b0110: c.sel = 4'b0100;
            4'b0111:          c.sel = 4'b1000;
            4'b1000:          c = '{neg: 1'b1, sel: 4'b1000};
            4'b1001, 4'b1010: c = '{neg: 1'b1, sel: 4'b0100};
            4'b1011, 4'b1100: c = '{neg: 1'b1, sel: 4'b0010};
            4'b1101, 4'b1110: c = '{neg: 1'b1, sel: 4'b0001};
            default:          c = '0;
        endcase
        return c;
    endfunction

    logic s1_valid, s2_valid;
    logic s1_adv, s2_adv, in_fire, s1_to_s2;

    assign s2_adv    = !s2_valid || out_ready;
    assign s1_adv    = !s1_valid || s2_adv;
    assign in_ready  = s1_adv;
    assign in_fire   = in_valid && s1_adv;
    assign s1_to_s2  = s1_valid && s2_adv;
    assign out_valid = s2_valid;

    // Operand extension; y_ext[0] is the implicit y[-1]=0 so digit i reads y_ext[3i +: 4]
    logic [PP_NBIT-1:0] x_ext;
    logic [PP_NBIT-1:0] x3_nxt;
    logic [YW:0]        y_ext;
    code_t [NUM_PP-1:0] code_nxt;

    assign x_ext  = {{3{tc & x[NBIT-1]}}, x};
    assign y_ext  = {{(YW - NBIT){tc & y[NBIT-1]}}, y, 1'b0};
    assign x3_nxt = x_ext + (x_ext << 1);

    // NOTE: every always_comb output gets a default before any conditional path, so no latch is inferred.
    always_comb begin
        code_nxt = '0;
        for (int i = 0; i < NUM_PP; i++) begin
            code_nxt[i] = booth_encode(y_ext[3*i +: 4]);
        end
    end

    logic [PP_NBIT-1:0] s1_x, s1_x2, s1_x3, s1_x4;
    code_t [NUM_PP-1:0] s1_code;
    logic [TAG_W-1:0]   s1_tag;

    // NOTE: state uses non-blocking assignments only; data registers get reset too, so outputs read 0 in reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_x     <= '0;
            s1_x2    <= '0;
            s1_x3    <= '0;
            s1_x4    <= '0;
            s1_code  <= '0;
            s1_tag   <= '0;
        end else begin
            if (s1_adv) s1_valid <= in_valid;
            if (in_fire) begin
                s1_x    <= x_ext;
                s1_x2   <= x_ext << 1;
                s1_x3   <= x3_nxt;
                s1_x4   <= x_ext << 2;
                s1_code <= code_nxt;
                s1_tag  <= in_tag;
            end
        end
    end

    logic [NUM_PP-1:0][PP_NBIT-1:0] mag;
    logic [NUM_PP-1:0][PP_NBIT-1:0] pp_nxt;
    logic [NUM_PP-1:0]              neg_nxt;

    always_comb begin
        mag     = '0;
        pp_nxt  = '0;
        neg_nxt = '0;
        for (int i = 0; i < NUM_PP; i++) begin
            mag[i] = ({PP_NBIT{s1_code[i].sel[0]}} & s1_x)
                   | ({PP_NBIT{s1_code[i].sel[1]}} & s1_x2)
                   | ({PP_NBIT{s1_code[i].sel[2]}} & s1_x3)
                   | ({PP_NBIT{s1_code[i].sel[3]}} & s1_x4);
`ifdef BOOTH_PP_ONECOMP_EN
            pp_nxt[i]  = s1_code[i].neg ? ~mag[i] : mag[i];
            neg_nxt[i] = s1_code[i].neg;
`else
            pp_nxt[i]  = s1_code[i].neg ? -mag[i] : mag[i];
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid <= 1'b0;
            pp       <= '0;
            pp_neg   <= '0;
            out_tag  <= '0;
        end else begin
            if (s2_adv) s2_valid <= s1_valid;
            if (s1_to_s2) begin
                pp      <= pp_nxt;
                pp_neg  <= neg_nxt;
                out_tag <= s1_tag;
            end
        end
    end

endmodule

// File: doc/booth_pp_pipe.md
# booth_pp_pipe

Pipelined, elastic radix-8 Booth partial-product generator for the mantissa multiplier. It accepts a multiplicand X and a multiplier Y, and forms the X multiples (including the hard 3X) in one register stage. It encodes Y into radix-8 digits, selects and negates the partial products in a second stage, and hands the vector to the compression tree over a valid/ready handshake. It generalises the combinational selector bank with parametrised width, a signed/unsigned operand mode, internal 3X generation, back-pressure, and a sideband tag.

## Interface
- NBIT, 24: operand width of X and Y.
- TAG_W, 4: sideband tag width, carried with the operands (minimum 1).
- NUM_PP, derived, NBIT/3+1 (integer division): number of partial products.
- PP_NBIT, derived, NBIT+3: partial-product width, two's complement.

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous active-high reset.
- in_valid  in  1  operand transfer request.
- in_ready  out  1  block can accept operands.
- tc  in  1  1 = X, Y are two's complement; 0 = unsigned.
- x  in  NBIT  multiplicand.
- y  in  NBIT  multiplier.
- in_tag  in  TAG_W  sideband, returned unchanged.
- out_valid  out  1  partial products valid.
- out_ready  in  1  downstream accepts.
- pp  out  NUM_PP×PP_NBIT  partial products; pp[i] carries weight 8^i.
- pp_neg  out  NUM_PP  +1 correction bits (see Configuration).
- out_tag  out  TAG_W  tag of the current output.

## Operation
- Operand extension:
  - X is extended to PP_NBIT bits: sign-extended if tc=1, zero-extended if tc=0.
  - Y is extended to 3·NUM_PP bits in the same way, and y[-1]=0 is appended below the LSB.
- Digit i = −4·y[3i+2] + 2·y[3i+1] + y[3i] + y[3i−1]. The range is −4..+4.
- Digit code (5 bits):
  - bit4 = negative.
  - bits3:0 = one-hot select of {4X,3X,2X,X}.
  - All-zero select means digit 0, and forces bit4=0.
- Stage 1 (S1) registers:
  - X, 2X, 4X as shifts of extended X.
  - 3X = X + 2X, full PP_NBIT adder; no overflow is possible.
  - All NUM_PP digit codes and the tag.
- Stage 2 (S2) registers:
  - pp[i] = selected multiple, negated when bit4=1.
  - pp_neg and the tag.
- Identity: Σ pp[i]·8^i (+ Σ pp_neg[i]·8^i) = X·Y under the selected mode, taken modulo 2^(PP_NBIT+3·NUM_PP−3).
- Elastic control:
  - s2_adv = !s2_valid | out_ready.
  - s1_adv = !s1_valid | s2_adv.
  - in_ready = s1_adv, combinational.
- Transfer rules:
  - An input transfer occurs when in_valid & in_ready.
  - An output transfer occurs when out_valid & out_ready.
  - Simultaneous input and output transfers in one cycle are legal; full throughput is 1 per cycle.
- Stall and valid rules:
  - While stalled, S1 and S2 contents and all outputs hold stable.
  - Data registers load only on a transfer.
  - Valid bits clear when their stage drains with nothing behind it.
- out_valid = s2_valid. pp, pp_neg and out_tag come directly from S2 registers.

## Timing
- Latency is 2 cycles: operands accepted at edge n appear on outputs after edge n+1 when there is no back-pressure.
- Capacity is 2 transactions. With out_ready=0 and both stages full, in_ready=0.
- in_ready depends combinationally on out_ready only; there is no path from in_valid to in_ready.
- Reset:
  - Async assert clears s1_valid and s2_valid immediately, so out_valid=0.
  - pp, pp_neg, out_tag and all data registers reset to 0.
  - in_ready reads 1 while in reset.
- Reset mid-operation discards all in-flight transactions.
- The first transfer is possible on the first rising edge after rst deasserts.
- Y = most-negative with tc=1, and X = most-negative with tc=1, are legal. −4X of the most-negative X fits in PP_NBIT.

## Configuration
- BOOTH_PP_ONECOMP_EN defined:
  - Negative partial products are emitted as one's complement (~multiple).
  - pp_neg[i]=1 for each negative digit; the tree adds it at weight 8^i.
- BOOTH_PP_ONECOMP_EN undefined:
  - pp[i] is the full two's complement value.
  - pp_neg is tied to 0.

## Test plan
- NBIT=8, tc=0, x=5, y=7, tag=3 -> 2 cycles later:
  - pp = {0, 5, 11'h7FB}, pp_neg=0, out_tag=3.
  - With BOOTH_PP_ONECOMP_EN: pp0=11'h7FA, pp_neg=3'b001.
- NBIT=8, tc=1, x=8'h80, y=8'h80 -> digits {−2,0,0}, pp = {11'h100, 0, 0}; the sum equals 16384.
- Back-to-back inputs with out_ready=1 for 10 cycles -> in_ready stays 1; 10 outputs in order, one per cycle, with matching tags.
- out_ready=0, 3 requests -> the first two are accepted, then in_ready=0. Raising out_ready drains them in order, and the third is accepted in the same cycle as the first output transfer.
- rst pulsed while both stages are full -> out_valid=0 at once, all outputs 0; no stale output after release.
- Random x, y, tc for 10k transfers with random out_ready -> the reconstructed sum equals the reference product.
